mmio_tx_port: RTL and testbench
===============================

// Module: mmio_tx_port
// PURPOSE
// - Memory-mapped byte-output port on the processor data bus, beside the data memory.
// - Decodes the core's data-bus signals (memwrite, ALU address, write data) in its address window.
// - Buffers written bytes in a FIFO and drains them on a valid/ready stream to an off-core consumer.
// - Supplies a read-data word that the top-level data mux selects whenever io_hit is 1.
// PARAMETERS
// - BASE_ADDR  32'hFFFF_FF00  byte address of the window; 16-byte aligned
// - DEPTH      8              FIFO entries; power of 2, >= 2
// - DATA_W     8              stream width; <= 8
// PORTS
// - clk         in   1       rising-edge clock, shared with the core
// - reset       in   1       asynchronous, active-high reset
// - memwrite    in   1       store strobe from the core
// - addr        in   32      byte address (ALU result)
// - writedata   in   32      store data
// - io_hit      out  1       addr[31:4] == BASE_ADDR[31:4]; combinational
// - io_rdata    out  32      read data for addr; combinational; 0 when !io_hit
// - tx_data     out  DATA_W  FIFO head byte
// - tx_valid    out  1       head is valid and drain is enabled
// - tx_ready    in   1       consumer accepts tx_data this cycle
// BEHAVIOUR
// - Register map (offset = addr[3:2]); addr[1:0] ignored.
//   - 0 DATA: a write pushes writedata[DATA_W-1:0]; a read returns the zero-extended head with no pop (0 if empty).
//   - 1 STATUS (RO): [0]=empty, [1]=full, [2]=overflow (sticky), [15:8]=count.
//   - 2 CTRL: [0]=en (R/W); a write of [1]=1 flushes (self-clearing, reads 0); a write of [2]=1 clears overflow.
//   - 3 reserved: reads 0; writes ignored.
// - Reads have no side effects; the core has no read strobe.
// - Write effect: a register write happens on the clk edge where memwrite & io_hit; state is visible the next cycle.
// - Reset (async, any time including mid-transfer):
//   - FIFO empty, count=0, en=0, overflow=0.
//   - tx_valid=0, tx_data=0.
//   - io_rdata follows decode of reset state.
// - Stream output:
//   - tx_valid = en & !empty.
//   - tx_data = head, held stable while tx_valid & !tx_ready.
//   - Pop on the edge where tx_valid & tx_ready; the next byte is presented the following cycle (1 byte/cycle max).
// - Push when not full: accepted. count width = $clog2(DEPTH)+1.
// - Push when full:
//   - With no pop that cycle: byte dropped, overflow<=1.
//   - With a pop the same cycle: push accepted, count unchanged, overflow unchanged.
// - Push and pop together when not full: both occur; count unchanged.
// - Push on empty: tx_valid rises the next cycle, if en; no bypass path.
// - Flush: rd/wr pointers and count go to 0 on the write edge; a same-cycle pop is discarded.
//   - en takes the value written in the same CTRL write.
// - en=0: FIFO keeps filling; nothing drains; tx_valid=0.
// - Clearing en while tx_valid & !tx_ready deasserts tx_valid; this is legal and the byte is kept.
// - Pointers wrap modulo DEPTH; full = (count == DEPTH).
// - Latency: store to DATA -> tx_valid at cycle +1 (en=1, FIFO was empty).
// STRUCTURE
// - Package mips_io_pkg:
//   - offsets OFF_DATA=2'd0, OFF_STATUS=2'd1, OFF_CTRL=2'd2
//   - STATUS/CTRL bit-index localparams
//   - typedef ctrl_t (en, flush, clr_ovf)
// - Sub-module fifo_sync #(DEPTH, DATA_W):
//   - inputs push, pop, flush, wdata
//   - outputs rdata, count, full, empty
// - Top level holds decode, CTRL/overflow flops and the read mux.
// TESTING
// - Reset, then read STATUS and CTRL -> STATUS=32'h0000_0001, CTRL=0, tx_valid=0.
// - en=1, tx_ready=1, store 0x41 then 0x42 to DATA on back-to-back cycles.
//   - Response: tx_data 0x41 then 0x42 on consecutive cycles; empty afterwards.
// - en=0, 9 stores 0x10..0x18 (DEPTH=8).
//   - Response: STATUS count=8, full=1, overflow=1; drain with en=1 yields 0x10..0x17 only.
// - FIFO full, tx_ready=1, store 0x55 on the same cycle as a pop.
//   - Response: overflow stays 0, count stays 8; 0x55 is the last byte out.
// - tx_ready=0 for 5 cycles with tx_valid=1 -> tx_data stable.
//   - Then a flush write to CTRL -> next cycle count=0, tx_valid=0.
// - Assert reset mid-drain, asynchronously between edges.
//   - Response: tx_valid=0 immediately, STATUS=1 after release; io_hit=0 for addr 0xFFFF_FEFC.

Source files
------------

// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped byte-output port.
// Holds the register offsets, STATUS/CTRL bit positions, the decoded CTRL
// write type and a helper that decodes the low CTRL write bits.
package mips_io_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int unsigned STATUS_EMPTY   = 0;
    localparam int unsigned STATUS_FULL    = 1;
    localparam int unsigned STATUS_OVF     = 2;
    localparam int unsigned STATUS_CNT_LSB = 8;
    localparam int unsigned STATUS_CNT_W   = 8;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;

    // Field order matches the CTRL bit layout (clr_ovf = bit 2, en = bit 0)
    typedef struct packed {
        logic clr_ovf;
        logic flush;
        logic en;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [2:0] bits);
        ctrl_t c;
        c.en      = bits[CTRL_EN];
        c.flush   = bits[CTRL_FLUSH];
        c.clr_ovf = bits[CTRL_CLR_OVF];
        return c;
    endfunction

endpackage

// File: rtl/mmio_tx_port_fifo_sync.sv
// Synchronous FIFO used as the byte buffer of mmio_tx_port.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   push, wdata    write request and data; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   pop            read request; ignored when empty
//   flush          clears pointers and count; overrides a same-cycle pop
//   rdata          head entry, 0 when empty
//   count          number of stored entries
//   full, empty    occupancy flags
module fifo_sync
    import mips_io_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Gate the head so stale storage never leaks out when empty
    assign rdata = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A pop frees a slot in the same cycle, so a push to a full FIFO still fits
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped byte-output port on the processor data bus.
// Stores to DATA are buffered in a FIFO and drained on a valid/ready stream.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   memwrite, addr,       core data-bus store strobe, byte address, store data
//   writedata
//   io_hit                addr falls in the 16-byte window (combinational)
//   io_rdata              read data for addr, 0 outside the window
//   tx_data, tx_valid,    output byte stream; tx_valid = en & !empty
//   tx_ready
// Map (addr[3:2]): 0 DATA, 1 STATUS (RO), 2 CTRL, 3 reserved.
module mmio_tx_port
    import mips_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic              io_hit,
    output logic [31:0]       io_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [1:0]        off;
    logic              reg_wr, data_wr, ctrl_wr;
    ctrl_t             ctrl_w;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic              fifo_pop, fifo_flush;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              unused_bits;

    assign unused_bits = ^{addr[1:0], writedata[31:8]};

    // Decode
    assign io_hit  = (addr[31:4] == BASE_ADDR[31:4]);
    assign off     = addr[3:2];
    assign reg_wr  = memwrite & io_hit;
    assign data_wr = reg_wr & (off == OFF_DATA);
    assign ctrl_wr = reg_wr & (off == OFF_CTRL);
    assign ctrl_w  = decode_ctrl(writedata[2:0]);

    // Stream side
    assign tx_valid   = en_q & ~empty;
    assign tx_data    = head;
    assign fifo_pop   = tx_valid & tx_ready;
    assign fifo_flush = ctrl_wr & ctrl_w.flush;

    fifo_sync #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (writedata[DATA_W-1:0]),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // CTRL and sticky overflow
    always_comb begin
        en_d  = en_q;
        ovf_d = ovf_q;
        if (ctrl_wr) begin
            en_d = ctrl_w.en;
            if (ctrl_w.clr_ovf) ovf_d = 1'b0;
        end
        // Full push is only lost when no pop frees a slot in the same cycle
        if (data_wr && full && !fifo_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end

    // Read mux; reads have no side effects
    always_comb begin
        io_rdata = '0;
        if (io_hit) begin
            unique case (off)
                OFF_DATA: io_rdata = 32'(head);
                OFF_STATUS: begin
                    io_rdata[STATUS_EMPTY] = empty;
                    io_rdata[STATUS_FULL]  = full;
                    io_rdata[STATUS_OVF]   = ovf_q;
                    io_rdata[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(count);
                end
                OFF_CTRL: io_rdata[CTRL_EN] = en_q;
                OFF_RSVD: io_rdata = '0;
                default:  io_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_tx_port.sv
module tb_mmio_tx_port;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        io_hit;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    mmio_tx_port #(
        .BASE_ADDR (BASE),
        .DEPTH     (8),
        .DATA_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .io_hit    (io_hit),
        .io_rdata  (io_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: every accepted byte must match the scoreboard head
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%02h expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    // One store, taking effect on the next rising edge
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        memwrite  = 1'b1;
        addr      = BASE + {28'h0, off, 2'b00};
        writedata = data;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] off, input logic [31:0] exp);
        addr = BASE + {28'h0, off, 2'b00};
        #1;
        check(name, io_rdata, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; addr = BASE; writedata = '0; tx_ready = 1'b0;
        cycles(2);
        reset = 1'b0;

        // Reset state
        rd("rst_status", 2'd1, 32'h0000_0001);
        rd("rst_ctrl", 2'd2, 32'h0);
        rd("rst_rsvd", 2'd3, 32'h0);
        rd("rst_data", 2'd0, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_io_hit", {31'h0, io_hit}, 32'h1);

        // Back-to-back stores drain on consecutive cycles
        wr(2'd2, 32'h1);
        tx_ready = 1'b1;
        sb_q.push_back(8'h41);
        sb_q.push_back(8'h42);
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        cycles(3);
        rd("b2b_status", 2'd1, 32'h0000_0001);

        // Overflow with drain disabled
        wr(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb_q.push_back(8'(8'h10 + i));
            wr(2'd0, 32'(8'h10 + i));
        end
        rd("ovf_status", 2'd1, 32'h0000_0806);
        rd("ovf_head", 2'd0, 32'h10);
        check("ovf_tx_valid", {31'h0, tx_valid}, 32'h0);
        wr(2'd2, 32'h1);
        cycles(10);
        rd("ovf_drained", 2'd1, 32'h0000_0005);
        wr(2'd2, 32'h5);
        rd("ovf_cleared", 2'd1, 32'h0000_0001);
        rd("ovf_ctrl", 2'd2, 32'h1);

        // Push on a full FIFO in the same cycle as a pop
        wr(2'd2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(8'(8'h20 + i));
            wr(2'd0, 32'(8'h20 + i));
        end
        rd("full_status", 2'd1, 32'h0000_0802);
        wr(2'd2, 32'h1);
        sb_q.push_back(8'h55);
        wr(2'd0, 32'h55);
        rd("fullpop_status", 2'd1, 32'h0000_0802);
        cycles(12);
        rd("fullpop_drained", 2'd1, 32'h0000_0001);

        // Back-pressure holds tx_data, then flush
        tx_ready = 1'b0;
        wr(2'd0, 32'h66);
        wr(2'd0, 32'h77);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'h0, tx_valid}, 32'h1);
            check("hold_data", {24'h0, tx_data}, 32'h66);
            cycles(1);
        end
        wr(2'd2, 32'h3);
        rd("flush_status", 2'd1, 32'h0000_0001);
        check("flush_tx_valid", {31'h0, tx_valid}, 32'h0);
        rd("flush_ctrl", 2'd2, 32'h1);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'(8'h30 + i));
            wr(2'd0, 32'(8'h30 + i));
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd("arst_status", 2'd1, 32'h0000_0001);
        rd("arst_ctrl", 2'd2, 32'h0);
        addr = 32'hFFFF_FEFC;
        #1;
        check("miss_io_hit", {31'h0, io_hit}, 32'h0);
        check("miss_rdata", io_rdata, 32'h0);
        cycles(2);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
